// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART core.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE
  } rx_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock oversample tick every CLK_DIV clocks.
module uart_baud_tick import uart_pkg::*; #(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int W = cnt_w(CLK_DIV);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_n)  cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: shared oversample tick, TX FSM, RX FSM with synchroniser and
// a single-entry holding register carrying data and error flags.
module uart_core import uart_pkg::*; #(
  parameter int      CLK_DIV    = 27,
  parameter int      OVERSAMPLE = 16,
  parameter int      DATA_BITS  = 8,
  parameter parity_e PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_line,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int STOP_TICKS = STOP_BITS * OVERSAMPLE;
  localparam int TW         = cnt_w(STOP_TICKS);
  localparam int BW         = cnt_w(DATA_BITS);

  logic tick;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // ---------------- TX ----------------
  tx_state_e            tx_state, tx_state_n;
  logic [TW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shr;
  logic                 tx_par, tx_pend, tx_bit_end;

  // tx_pend covers the wait between accept and the first tick, so START is a full bit.
  assign tx_ready = (tx_state == TX_IDLE) && !tx_pend;

  always_comb begin
    tx_state_n = tx_state;
    tx_line    = 1'b1;
    tx_bit_end = tick && (tx_cnt == TW'(OVERSAMPLE - 1));
    case (tx_state)
      TX_IDLE:   if (tx_pend && tick) tx_state_n = TX_START;
      TX_START:  begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_state_n = TX_DATA;
      end
      TX_DATA:   begin
        tx_line = tx_shr[0];
        if (tx_bit_end && tx_idx == BW'(DATA_BITS - 1))
          tx_state_n = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
      end
      TX_PARITY: begin
        tx_line = tx_par;
        if (tx_bit_end) tx_state_n = TX_STOP;
      end
      TX_STOP:   if (tick && tx_cnt == TW'(STOP_TICKS - 1)) tx_state_n = TX_IDLE;
      default:   tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shr   <= '0;
      tx_par   <= 1'b0;
      tx_pend  <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      if (tx_valid && tx_ready) begin
        tx_shr  <= tx_data;
        tx_par  <= (PARITY == PAR_EVEN) ? ^tx_data : ~^tx_data;
        tx_pend <= 1'b1;
      end else if (tx_state == TX_STOP && tx_state_n == TX_IDLE) begin
        tx_pend <= 1'b0;
      end
      // STOP counts across all stop bits, every other state restarts per bit.
      if (tx_state == TX_IDLE) tx_cnt <= '0;
      else if (tick)           tx_cnt <= (tx_bit_end && tx_state != TX_STOP) ? '0 : tx_cnt + 1'b1;
      if (tx_state == TX_START) tx_idx <= '0;
      else if (tx_state == TX_DATA && tx_bit_end) begin
        tx_idx <= tx_idx + 1'b1;
        tx_shr <= tx_shr >> 1;
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_e            rx_state, rx_state_n;
  logic                 rx_s1, rx_s2;
  logic [TW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shr;
  logic                 rx_perr, rx_samp, rx_done, rx_load;

  always_comb begin
    rx_state_n = rx_state;
    rx_done    = 1'b0;
    rx_samp    = tick && (rx_cnt == ((rx_state == RX_START) ? TW'(OVERSAMPLE / 2 - 1)
                                                            : TW'(OVERSAMPLE - 1)));
    case (rx_state)
      RX_IDLE:      if (tick && !rx_s2) rx_state_n = RX_START;
      RX_START:     if (rx_samp) rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_samp && rx_idx == BW'(DATA_BITS - 1))
                      rx_state_n = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
      RX_PARITY:    if (rx_samp) rx_state_n = RX_STOP;
      RX_STOP:      if (rx_samp) begin
        rx_done    = 1'b1;
        rx_state_n = rx_s2 ? RX_IDLE : RX_WAIT_IDLE;
      end
      RX_WAIT_IDLE: if (rx_s2) rx_state_n = RX_IDLE;
      default:      rx_state_n = RX_IDLE;
    endcase
    rx_load = rx_done && (!rx_valid || rx_ready);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shr        <= '0;
      rx_perr       <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      break_det     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_s1    <= rx_serial;
      rx_s2    <= rx_s1;
      rx_state <= rx_state_n;
      if (rx_state == RX_IDLE) rx_cnt <= '0;
      else if (tick)           rx_cnt <= rx_samp ? '0 : rx_cnt + 1'b1;
      if (rx_state == RX_START) begin
        rx_idx  <= '0;
        rx_perr <= 1'b0;
      end else if (rx_state == RX_DATA && rx_samp) begin
        rx_shr <= {rx_s2, rx_shr[DATA_BITS-1:1]};
        rx_idx <= rx_idx + 1'b1;
      end else if (rx_state == RX_PARITY && rx_samp) begin
        rx_perr <= rx_s2 ^ ((PARITY == PAR_EVEN) ? ^rx_shr : ~^rx_shr);
      end
      // A full holding register keeps its word; the new frame is only reported.
      overrun <= rx_done && !rx_load;
      if (rx_load) begin
        rx_valid      <= 1'b1;
        rx_data       <= rx_shr;
        parity_error  <= rx_perr;
        framing_error <= !rx_s2;
        break_det     <= !rx_s2 && (rx_shr == '0);
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench: an 8N1 instance (with optional loopback) and an 8E1 instance.
module tb_uart_core;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tx_data_n = 8'h00, rx_data_n;
  logic tx_valid_n = 1'b0, tx_ready_n, tx_line_n, rx_serial_n, rx_valid_n, rx_ready_n = 1'b0;
  logic pe_n, fe_n, bk_n, ov_n;
  logic drv_n = 1'b1, lb = 1'b0;
  assign rx_serial_n = lb ? tx_line_n : drv_n;

  logic [7:0] tx_data_e = 8'h00, rx_data_e;
  logic tx_valid_e = 1'b0, tx_ready_e, tx_line_e, rx_serial_e, rx_valid_e, rx_ready_e = 1'b0;
  logic pe_e, fe_e, bk_e, ov_e;
  logic drv_e = 1'b1;
  assign rx_serial_e = drv_e;

  uart_core #(.CLK_DIV(2), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u_n (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n),
    .tx_line(tx_line_n), .rx_serial(rx_serial_n), .rx_data(rx_data_n), .rx_valid(rx_valid_n),
    .rx_ready(rx_ready_n), .parity_error(pe_n), .framing_error(fe_n), .break_det(bk_n), .overrun(ov_n)
  );

  uart_core #(.CLK_DIV(2), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_e (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e),
    .tx_line(tx_line_e), .rx_serial(rx_serial_e), .rx_data(rx_data_e), .rx_valid(rx_valid_e),
    .rx_ready(rx_ready_e), .parity_error(pe_e), .framing_error(fe_e), .break_det(bk_e), .overrun(ov_e)
  );

  int n_chk = 0, n_fail = 0;
  int ov_cnt = 0;
  always @(negedge clk) if (ov_n === 1'b1) ov_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bits(input bit e, input logic v, input int n);
    if (e) drv_e = v; else drv_n = v;
    repeat (n * 32) @(negedge clk);
  endtask

  task automatic frame(input bit e, input logic [7:0] d, input bit has_par, input logic par,
                       input logic stop);
    bits(e, 1'b0, 1);
    for (int i = 0; i < 8; i++) bits(e, d[i], 1);
    if (has_par) bits(e, par, 1);
    bits(e, stop, 1);
    if (e) drv_e = 1'b1; else drv_n = 1'b1;
  endtask

  task automatic consume(input bit e, input string tag);
    if (e) rx_ready_e = 1'b1; else rx_ready_n = 1'b1;
    @(negedge clk);
    rx_ready_e = 1'b0;
    rx_ready_n = 1'b0;
    chk(tag, e ? rx_valid_e : rx_valid_n, 0);
  endtask

  task automatic wait_rx_n(input string tag);
    int k;
    k = 0;
    while (rx_valid_n !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    chk(tag, rx_valid_n, 1);
  endtask

  initial begin
    int k, ov0;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_line", tx_line_n, 1);
    chk("rst_tx_ready", tx_ready_n, 1);
    chk("rst_rx_valid", rx_valid_n, 0);
    chk("rst_rx_data", rx_data_n, 0);
    chk("rst_flags", {pe_n, fe_n, bk_n, ov_n}, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: 8N1 loopback of 0x4D, busy window ~10 bit times
    lb = 1'b1;
    tx_data_n = 8'h4D; tx_valid_n = 1'b1;
    @(negedge clk);
    tx_valid_n = 1'b0; tx_data_n = 8'hFF;
    k = 0;
    while (tx_ready_n !== 1'b1 && k < 1000) begin k++; @(negedge clk); end
    chk("t1_busy_len_ok", (k >= 318 && k <= 322), 1);
    wait_rx_n("t1_rx_valid");
    chk("t1_rx_data", rx_data_n, 8'h4D);
    chk("t1_flags", {pe_n, fe_n, bk_n}, 0);
    consume(0, "t1_consume");
    lb = 1'b0;

    // 2: even parity TX bit and RX parity check
    tx_data_e = 8'h4D; tx_valid_e = 1'b1;
    @(negedge clk);
    tx_valid_e = 1'b0;
    k = 0;
    while (tx_line_e !== 1'b0 && k < 10) begin @(negedge clk); k++; end
    chk("t2_start", tx_line_e, 0);
    repeat (48) @(negedge clk);
    chk("t2_bit0", tx_line_e, 1);
    repeat (256) @(negedge clk);
    chk("t2_parity_bit", tx_line_e, 0);
    repeat (32) @(negedge clk);
    chk("t2_stop_bit", tx_line_e, 1);
    frame(1, 8'h4D, 1, 1'b1, 1'b1);
    chk("t2_rx_valid", rx_valid_e, 1);
    chk("t2_rx_data", rx_data_e, 8'h4D);
    chk("t2_perr_set", pe_e, 1);
    consume(1, "t2_consume");
    frame(1, 8'h4D, 1, 1'b0, 1'b1);
    chk("t2_perr_clr", {rx_valid_e, pe_e, fe_e, bk_e, ov_e}, 5'b10000);
    consume(1, "t2_consume2");
    chk("t2_tx_ready", tx_ready_e, 1);

    // 3: framing error, then break held low for 20 bit times
    frame(0, 8'hA5, 0, 1'b0, 1'b0);
    chk("t3_fe_valid", rx_valid_n, 1);
    chk("t3_fe_data", rx_data_n, 8'hA5);
    chk("t3_fe_flags", {fe_n, bk_n, pe_n}, 3'b100);
    consume(0, "t3_fe_consume");
    bits(0, 1'b1, 1);
    bits(0, 1'b0, 10);
    chk("t3_brk_valid", rx_valid_n, 1);
    chk("t3_brk_data", rx_data_n, 0);
    chk("t3_brk_flags", {fe_n, bk_n}, 2'b11);
    consume(0, "t3_brk_consume");
    bits(0, 1'b0, 10);
    chk("t3_brk_hold", rx_valid_n, 0);
    bits(0, 1'b1, 2);
    chk("t3_idle_after", rx_valid_n, 0);
    frame(0, 8'h5A, 0, 1'b0, 1'b1);
    chk("t3_recover_data", rx_data_n, 8'h5A);
    chk("t3_recover_flags", {rx_valid_n, fe_n, bk_n}, 3'b100);
    consume(0, "t3_recover_consume");

    // 4: overrun while holding 0x11
    ov0 = ov_cnt;
    frame(0, 8'h11, 0, 1'b0, 1'b1);
    frame(0, 8'h22, 0, 1'b0, 1'b1);
    chk("t4_overrun_pulses", ov_cnt - ov0, 1);
    chk("t4_held_data", rx_data_n, 8'h11);
    chk("t4_held_valid", {rx_valid_n, fe_n}, 2'b10);
    consume(0, "t4_consume");

    // 5: glitch rejection, then back-to-back TX 0x00 / 0xFF over loopback
    drv_n = 1'b0;
    repeat (4) @(negedge clk);
    drv_n = 1'b1;
    repeat (64) @(negedge clk);
    chk("t5_glitch", rx_valid_n, 0);
    ov0 = ov_cnt;
    lb = 1'b1;
    tx_data_n = 8'h00; tx_valid_n = 1'b1;
    @(negedge clk);
    tx_data_n = 8'hFF;
    k = 0;
    while (tx_ready_n !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    chk("t5_ready_again", tx_ready_n, 1);
    @(negedge clk);
    tx_valid_n = 1'b0;
    chk("t5_b2b_accept", tx_ready_n, 0);
    wait_rx_n("t5_rx0_valid");
    chk("t5_rx0_data", rx_data_n, 8'h00);
    consume(0, "t5_rx0_consume");
    wait_rx_n("t5_rx1_valid");
    chk("t5_rx1_data", rx_data_n, 8'hFF);
    consume(0, "t5_rx1_consume");
    chk("t5_no_overrun", ov_cnt - ov0, 0);
    repeat (40) @(negedge clk);
    lb = 1'b0;

    // 6: reset mid-TX and mid-RX with a word held
    frame(0, 8'h77, 0, 1'b0, 1'b1);
    chk("t6_held", rx_valid_n, 1);
    tx_data_n = 8'hAA; tx_valid_n = 1'b1; drv_n = 1'b0;
    @(negedge clk);
    tx_valid_n = 1'b0;
    repeat (100) @(negedge clk);
    chk("t6_busy_line", {tx_ready_n, tx_line_n}, 2'b00);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_line", tx_line_n, 1);
    chk("t6_rst_ready", tx_ready_n, 1);
    chk("t6_rst_valid", rx_valid_n, 0);
    chk("t6_rst_data", rx_data_n, 0);
    reset_n = 1'b1; drv_n = 1'b1;
    repeat (64) @(negedge clk);
    frame(0, 8'h3C, 0, 1'b0, 1'b1);
    chk("t6_rx_data", rx_data_n, 8'h3C);
    chk("t6_rx_flags", {rx_valid_n, pe_n, fe_n, bk_n}, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
